// File: rtl/rv32_decode_stage.sv
// RV32I decode pipeline stage: valid/ready handshake, field split, one-hot funct7 class,
// sign-extended immediate, illegal-encoding flag and a saturating illegal-instruction counter.
module rv32_decode_stage #(
  parameter bit              EN_M        = 1'b1,
  parameter bit              EN_CUSTOM   = 1'b1,
  parameter logic [6:0]      CUST_OPCODE = 7'h0B,
  parameter int unsigned     CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_f3,
  output logic [4:0]       out_f7_oh,
  output logic [31:0]      out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned XLEN = 32;

  logic [6:0]       opcode_c;
  logic [2:0]       f3_c;
  logic [6:0]       f7_c;
  logic [4:0]       f7_oh_d;
  logic [XLEN-1:0]  imm_d;
  logic             illegal_d;
  logic             accept;

  logic             valid_q;
  logic [XLEN-1:0]  pc_q;
  logic [6:0]       opcode_q;
  logic [4:0]       rd_q;
  logic [4:0]       rs1_q;
  logic [4:0]       rs2_q;
  logic [2:0]       f3_q;
  logic [4:0]       f7_oh_q;
  logic [XLEN-1:0]  imm_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  assign opcode_c = in_instr[6:0];
  assign f3_c     = in_instr[14:12];
  assign f7_c     = in_instr[31:25];
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // funct7 class, MSB..LSB = {0x20, 0x03, 0x02, 0x01, 0x00}
  always_comb begin
    f7_oh_d = 5'b00000;
    case (f7_c)
      7'h00:   f7_oh_d = 5'b00001;
      7'h01:   f7_oh_d = 5'b00010;
      7'h02:   f7_oh_d = 5'b00100;
      7'h03:   f7_oh_d = 5'b01000;
      7'h20:   f7_oh_d = 5'b10000;
      default: f7_oh_d = 5'b00000;
    endcase
  end

  // Immediate assembly; every format sign-extends from instr[31]
  always_comb begin
    imm_d = '0;
    case (opcode_c)
      7'h03, 7'h13, 7'h67, 7'h73:
        imm_d = {{20{in_instr[31]}}, in_instr[31:20]};
      7'h23:
        imm_d = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      7'h63:
        imm_d = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
      7'h37, 7'h17:
        imm_d = {in_instr[31:12], 12'h000};
      7'h6F:
        imm_d = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      default:
        imm_d = '0;
    endcase
  end

  // Encoding legality; the custom group is matched in default so it cannot shadow a base opcode
  always_comb begin
    illegal_d = 1'b0;
    case (opcode_c)
      7'h03, 7'h0F, 7'h17, 7'h23, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73:
        illegal_d = 1'b0;
      7'h13: begin
        if (f3_c == 3'd1)
          illegal_d = (f7_c != 7'h00);
        else if (f3_c == 3'd5)
          illegal_d = (f7_c != 7'h00) && (f7_c != 7'h20);
        else
          illegal_d = 1'b0;
      end
      7'h33: begin
        case (f7_c)
          7'h00:   illegal_d = 1'b0;
          7'h20:   illegal_d = !((f3_c == 3'd0) || (f3_c == 3'd5));
          7'h01:   illegal_d = !EN_M;
          default: illegal_d = 1'b1;
        endcase
      end
      default:
        illegal_d = !(EN_CUSTOM && (opcode_c == CUST_OPCODE) && (f7_c <= 7'h03));
    endcase
  end

  // Output register: flush drops the held and incoming instruction; stall holds everything
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      opcode_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      f3_q      <= '0;
      f7_oh_q   <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      pc_q      <= in_pc;
      opcode_q  <= opcode_c;
      rd_q      <= in_instr[11:7];
      rs1_q     <= in_instr[19:15];
      rs2_q     <= in_instr[24:20];
      f3_q      <= f3_c;
      f7_oh_q   <= f7_oh_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
      if (illegal_d && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_opcode  = opcode_q;
  assign out_rd      = rd_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_f3      = f3_q;
  assign out_f7_oh   = f7_oh_q;
  assign out_imm     = imm_q;
  assign out_illegal = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: two instances (default parameters and EN_M=0/EN_CUSTOM=0/CNT_W=2)
// share one stimulus stream and are checked against a behavioural model every cycle.
module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_in_ready, a_valid, a_ill, b_in_ready, b_valid, b_ill;
  logic [31:0] a_pc, a_imm, b_pc, b_imm;
  logic [6:0]  a_op, b_op;
  logic [4:0]  a_rd, a_rs1, a_rs2, a_f7, b_rd, b_rs1, b_rs2, b_f7;
  logic [2:0]  a_f3, b_f3;
  logic [7:0]  a_cnt;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rv32_decode_stage u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(a_valid), .out_ready(out_ready), .out_pc(a_pc),
    .out_opcode(a_op), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_f3(a_f3),
    .out_f7_oh(a_f7), .out_imm(a_imm), .out_illegal(a_ill), .illegal_cnt(a_cnt));

  rv32_decode_stage #(.EN_M(1'b0), .EN_CUSTOM(1'b0), .CUST_OPCODE(7'h0B), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(b_valid), .out_ready(out_ready), .out_pc(b_pc),
    .out_opcode(b_op), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_f3(b_f3),
    .out_f7_oh(b_f7), .out_imm(b_imm), .out_illegal(b_ill), .illegal_cnt(b_cnt));

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [4:0]  f7_oh;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input bit en_m, input bit en_c);
    exp_t e;
    int   sx;
    int   op, f3, f7;
    bit   legal;
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    sx = $signed(ins);
    e.pc = pc; e.opcode = ins[6:0]; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.f3 = ins[14:12];
    e.f7_oh = 5'b0;
    if (f7 <= 3)       e.f7_oh = 5'(1 << f7);
    else if (f7 == 32) e.f7_oh = 5'b10000;
    case (op)
      'h03, 'h13, 'h67, 'h73: e.imm = 32'(sx >>> 20);
      'h23: e.imm = 32'(((sx >>> 25) << 5) | int'(ins[11:7]));
      'h63: e.imm = 32'(((sx >>> 31) << 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5)
                        | (int'(ins[11:8]) << 1));
      'h37, 'h17: e.imm = ins & 32'hFFFF_F000;
      'h6F: e.imm = 32'(((sx >>> 31) << 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11)
                        | (int'(ins[30:21]) << 1));
      default: e.imm = 32'h0;
    endcase
    legal = op inside {'h03, 'h0F, 'h13, 'h17, 'h23, 'h33, 'h37, 'h63, 'h67, 'h6F, 'h73}
            || (en_c && op == 'h0B);
    if (op == 'h33)
      legal = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && en_m);
    if (op == 'h13 && f3 == 1) legal = (f7 == 0);
    if (op == 'h13 && f3 == 5) legal = (f7 == 0 || f7 == 'h20);
    if (en_c && op == 'h0B)    legal = (f7 <= 3);
    e.illegal = !legal;
    return e;
  endfunction

  // Behavioural model state, one copy per instance
  bit   mv_a, mv_b;
  exp_t me_a, me_b;
  int   mc_a, mc_b;

  always @(posedge clk) begin
    exp_t da, db;
    bit acc;
    da  = model_decode(in_instr, in_pc, 1'b1, 1'b1);
    db  = model_decode(in_instr, in_pc, 1'b0, 1'b0);
    acc = in_valid && (!mv_a || out_ready);
    if (rst) begin
      mv_a = 0; mv_b = 0; me_a = '0; me_b = '0; mc_a = 0; mc_b = 0;
    end else if (flush) begin
      mv_a = 0; mv_b = 0;
    end else if (acc) begin
      mv_a = 1; mv_b = 1; me_a = da; me_b = db;
      if (da.illegal && mc_a < 255) mc_a++;
      if (db.illegal && mc_b < 3)   mc_b++;
    end else if (out_ready) begin
      mv_a = 0; mv_b = 0;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a_valid", 32'(a_valid), 32'(mv_a));
      cmp("a_in_ready", 32'(a_in_ready), 32'(!mv_a || out_ready));
      cmp("a_cnt", 32'(a_cnt), 32'(mc_a));
      cmp("a_fields", {a_op, a_rd, a_rs1, a_rs2, a_f3, a_f7, a_ill},
          {me_a.opcode, me_a.rd, me_a.rs1, me_a.rs2, me_a.f3, me_a.f7_oh, me_a.illegal});
      cmp("a_pc", a_pc, me_a.pc);
      cmp("a_imm", a_imm, me_a.imm);
      cmp("b_valid", 32'(b_valid), 32'(mv_b));
      cmp("b_in_ready", 32'(b_in_ready), 32'(!mv_b || out_ready));
      cmp("b_cnt", 32'(b_cnt), 32'(mc_b));
      cmp("b_fields", {b_op, b_rd, b_rs1, b_rs2, b_f3, b_f7, b_ill},
          {me_b.opcode, me_b.rd, me_b.rs1, me_b.rs2, me_b.f3, me_b.f7_oh, me_b.illegal});
      cmp("b_pc", b_pc, me_b.pc);
      cmp("b_imm", b_imm, me_b.imm);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v; in_instr = ins; in_pc = pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [14] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63,
                             7'h67, 7'h6F, 7'h73, 7'h0B, 7'h7F, 7'h33};
    logic [6:0] f7s [6]  = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h20, 7'h00};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0]   = ops[$urandom_range(0, 13)];
    if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 5)];
    return w;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    cmp("rst_valid", 32'(a_valid), 32'd0);
    cmp("rst_cnt", 32'(a_cnt), 32'd0);
    cmp("rst_in_ready", 32'(a_in_ready), 32'd1);

    drive(1'b1, 32'h40B5_0533, 32'h100);
    tick();
    cmp("sub_valid", 32'(a_valid), 32'd1);
    cmp("sub_f7oh", 32'(a_f7), 32'b10000);
    cmp("sub_regs", {17'h0, a_rd, a_rs1, a_rs2}, {17'h0, 5'd10, 5'd10, 5'd11});
    cmp("sub_illegal", 32'(a_ill), 32'd0);

    drive(1'b1, 32'h02B5_0533, 32'h104);
    tick();
    cmp("mul_f7oh", 32'(a_f7), 32'b00010);
    cmp("mul_legal_m", 32'(a_ill), 32'd0);
    cmp("mul_illegal_nom", 32'(b_ill), 32'd1);
    cmp("mul_cnt_nom", 32'(b_cnt), 32'd1);

    drive(1'b1, 32'hFFF0_0093, 32'h108);
    tick();
    cmp("addi_imm", a_imm, 32'hFFFF_FFFF);
    drive(1'b1, 32'hFE00_0EE3, 32'h10C);
    tick();
    cmp("beq_imm", a_imm, 32'hFFFF_FFFC);

    drive(1'b1, 32'h0000_007F, 32'h110);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    cmp("flush_valid", 32'(a_valid), 32'd0);
    cmp("flush_cnt_a", 32'(a_cnt), 32'd0);
    cmp("flush_cnt_b", 32'(b_cnt), 32'd1);

    out_ready = 1'b0;
    drive(1'b1, 32'h00A0_0113, 32'h200);
    tick();
    cmp("bp_first_pc", a_pc, 32'h200);
    cmp("bp_in_ready", 32'(a_in_ready), 32'd0);
    drive(1'b1, 32'h00B0_0193, 32'h204);
    repeat (2) tick();
    cmp("bp_hold_pc", a_pc, 32'h200);
    cmp("bp_hold_imm", a_imm, 32'd10);
    out_ready = 1'b1;
    tick();
    cmp("bp_second_pc", a_pc, 32'h204);
    cmp("bp_second_imm", a_imm, 32'd11);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    cmp("bp_drain", 32'(a_valid), 32'd0);

    drive(1'b1, 32'h0000_007F, 32'h300);
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("sat_cnt_b", 32'(b_cnt), (i == 0) ? 32'd2 : 32'd3);
      cmp("cnt_a", 32'(a_cnt), 32'(i + 1));
    end

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom);
      tick();
    end
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
